// File: rtl/cache_arbiter.sv
// Two-client (I-cache / D-cache) arbiter in front of one physical memory port.
// Define CACHE_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; default is fixed D-priority.
module cache_arbiter (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_read,
  input  logic [15:0]  i_address,
  output logic [127:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [15:0]  d_address,
  input  logic [127:0] d_wdata,
  output logic [127:0] d_rdata,
  output logic         d_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t         state;
  logic [15:0]    addr_q;
  logic [127:0]   wdata_q;
  logic           op_write_q;
  logic           i_req;
  logic           d_req;
  logic           grant_d;
  logic           grant_i;

  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
  logic prio_d;
  assign grant_d = d_req & (~i_req | prio_d);
`else
  assign grant_d = d_req;
`endif
  assign grant_i = i_req & ~grant_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      op_write_q <= 1'b0;
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
      prio_d     <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= SERVE_D;
            addr_q     <= d_address;
            wdata_q    <= d_wdata;
            op_write_q <= d_write;
          end else if (grant_i) begin
            state      <= SERVE_I;
            addr_q     <= i_address;
            op_write_q <= 1'b0;
          end
        end
        SERVE_I: begin
          if (pmem_resp) begin
            state <= IDLE;
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
            prio_d <= 1'b1;
`endif
          end
        end
        SERVE_D: begin
          if (pmem_resp) begin
            state <= IDLE;
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
            prio_d <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode the registered state/op; rst gating silences them during the reset cycle.
  assign pmem_read    = (state != IDLE) & ~op_write_q & ~rst;
  assign pmem_write   = (state != IDLE) &  op_write_q & ~rst;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;
  assign i_resp  = (state == SERVE_I) & pmem_resp & ~rst;
  assign d_resp  = (state == SERVE_D) & pmem_resp & ~rst;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter; expectations follow CACHE_ARBITER_ROUND_ROBIN_EN when defined.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_read;
  logic [15:0]  i_address;
  logic [127:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [15:0]  d_address;
  logic [127:0] d_wdata;
  logic [127:0] d_rdata;
  logic         d_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int vectors = 0;
  int errors  = 0;
  int i_resp_count;
  logic rr;
  logic [127:0] a5_line;
  logic [127:0] wb_line;

  cache_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    a5_line = {16{8'hA5}};
    wb_line = 128'h0123456789ABCDEF0123456789ABCDEF;
    rst = 1'b1; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
    d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 0;

    // Reset state
    step(); step();
    chk("rst_pmem_read",  pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    pmem_resp = 1; #1;
    chk("rst_i_resp", i_resp, 0);
    chk("rst_d_resp", d_resp, 0);
    pmem_resp = 0;
    chk("rst_addr",  pmem_address, 16'h0000);
    chk("rst_wdata", pmem_wdata, 128'h0);
    rst = 0;
    step();

    // I-only read, response after 3 cycles
    i_read = 1; i_address = 16'h0040;
    step();
    chk("i_strobe", pmem_read, 1);
    chk("i_nowrite", pmem_write, 0);
    chk("i_addr", pmem_address, 16'h0040);
    step();
    chk("i_wait_resp", i_resp, 0);
    step();
    chk("i_wait_read", pmem_read, 1);
    pmem_resp = 1; pmem_rdata = a5_line; #1;
    chk("i_resp", i_resp, 1);
    chk("i_d_resp", d_resp, 0);
    chk("i_rdata", i_rdata, a5_line);
    chk("i_d_rdata_copy", d_rdata, a5_line);
    i_read = 0;
    step();
    pmem_resp = 0; #1;
    chk("i_done_read", pmem_read, 0);
    chk("i_done_resp", i_resp, 0);

    // Simultaneous requests; D re-requests immediately to create a second contest
    i_read = 1; i_address = 16'h0100; d_read = 1; d_address = 16'h0200;
    step();
    chk("sim_first_addr", pmem_address, 16'h0200);
    chk("sim_first_read", pmem_read, 1);
    pmem_resp = 1; #1;
    chk("sim_first_d_resp", d_resp, 1);
    chk("sim_first_i_resp", i_resp, 0);
    step();
    pmem_resp = 0; #1;
    chk("sim_gap_read", pmem_read, 0);
    step();
    chk("sim_second_addr", pmem_address, rr ? 16'h0100 : 16'h0200);
    pmem_resp = 1; #1;
    chk("sim_second_i_resp", i_resp, rr);
    chk("sim_second_d_resp", d_resp, !rr);
    if (rr) i_read = 0; else d_read = 0;
    step();
    pmem_resp = 0; #1;
    chk("sim_gap2_read", pmem_read, 0);
    step();
    chk("sim_third_addr", pmem_address, rr ? 16'h0200 : 16'h0100);
    pmem_resp = 1; #1;
    chk("sim_third_i_resp", i_resp, !rr);
    i_read = 0; d_read = 0;
    step();
    pmem_resp = 0;

    // Write-back with address/data churn after grant
    d_write = 1; d_address = 16'h1230; d_wdata = wb_line;
    step();
    chk("wb_write", pmem_write, 1);
    chk("wb_read", pmem_read, 0);
    chk("wb_addr", pmem_address, 16'h1230);
    chk("wb_wdata", pmem_wdata, wb_line);
    d_address = 16'hFFFF; d_wdata = '1;
    step();
    chk("wb_addr_hold", pmem_address, 16'h1230);
    chk("wb_wdata_hold", pmem_wdata, wb_line);
    chk("wb_write_hold", pmem_write, 1);
    pmem_resp = 1; #1;
    chk("wb_d_resp", d_resp, 1);
    d_write = 0;
    step();
    pmem_resp = 0; #1;
    chk("wb_idle_write", pmem_write, 0);
    chk("wb_idle_addr_kept", pmem_address, 16'h1230);

    // d_read and d_write together latch a write
    d_read = 1; d_write = 1; d_address = 16'h2000;
    step();
    chk("rw_write", pmem_write, 1);
    chk("rw_read", pmem_read, 0);
    pmem_resp = 1; d_read = 0; d_write = 0;
    step();
    pmem_resp = 0;

    // Reset mid-transaction coincident with pmem_resp
    d_read = 1; d_address = 16'h3000;
    step();
    chk("mid_read", pmem_read, 1);
    rst = 1; pmem_resp = 1; #1;
    chk("mid_d_resp", d_resp, 0);
    chk("mid_read_gated", pmem_read, 0);
    d_read = 0;
    step();
    rst = 0; pmem_resp = 0; #1;
    chk("mid_after_read", pmem_read, 0);
    chk("mid_after_write", pmem_write, 0);
    chk("mid_after_addr", pmem_address, 16'h0000);

    // Spurious response in IDLE
    pmem_resp = 1; #1;
    chk("spur_i_resp", i_resp, 0);
    chk("spur_d_resp", d_resp, 0);
    step();
    pmem_resp = 0; #1;
    chk("spur_no_strobe", pmem_read, 0);

    // Request dropped before grant edge
    i_read = 1; i_address = 16'h0777; #2; i_read = 0;
    step();
    chk("drop_no_strobe", pmem_read, 0);

    // Back-to-back I reads with i_read held
    i_read = 1; i_address = 16'h0500; i_resp_count = 0;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("b2b_strobe", pmem_read, 1);
      pmem_resp = 1; #1;
      if (i_resp) i_resp_count++;
      step();
      pmem_resp = 0; #1;
      chk("b2b_gap", pmem_read, 0);
      chk("b2b_no_extra_resp", i_resp, 0);
    end
    chk("b2b_resp_count", i_resp_count, 3);
    i_read = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
